// File: rtl/fp_mul_issue.sv
// fp_mul_issue
//
// Issue/collect stage sitting in front of a multi-cycle single-precision
// multiplier. It accepts one operand pair at a time over a valid/ready
// handshake and launches the multiplier with a one-cycle mul_start pulse.
// When the multiplier reports mul_done, the result is captured into a small
// FIFO for the downstream consumer. A watchdog retires an operation that never
// completes. Such an operation is pushed as a quiet NaN with out_timeout set,
// so the pipeline cannot deadlock.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : operand handshake, in_op1/in_op2 operands
//   mul_start           : one-cycle launch pulse, mul_op1/mul_op2 held operands
//   mul_done            : multiplier completion, with mul_result/mul_overflow
//   out_valid/out_ready : result FIFO head handshake
//   out_result          : head product
//   out_overflow        : head overflow flag
//   out_timeout         : head entry was retired by the watchdog
//   busy                : an operation is in flight (ISSUE or WAIT)
//   count               : FIFO occupancy
//
// FSM states
//   state   | meaning
//   IDLE    | no op in flight; accepts a pair when the FIFO has room
//   ISSUE   | mul_start pulse cycle; watchdog cleared
//   WAIT    | operands held; wait for mul_done or watchdog expiry

module fp_mul_issue #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_op1,
    input  logic [31:0]              in_op2,
    output logic                     mul_start,
    output logic [31:0]              mul_op1,
    output logic [31:0]              mul_op2,
    input  logic                     mul_done,
    input  logic                     mul_overflow,
    input  logic [31:0]              mul_result,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_result,
    output logic                     out_overflow,
    output logic                     out_timeout,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned WW = $clog2(TIMEOUT);

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [31:0]     op1_q, op1_d;
    logic [31:0]     op2_q, op2_d;
    logic [WW-1:0]   wd_q, wd_d;

    logic [33:0]     mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    logic            push;
    logic [33:0]     push_data;
    logic            pop;
    logic            has_room;
    logic            accept;
    logic [33:0]     head;

    assign has_room = (count_q < CW'(DEPTH));

    // Outputs are forced low while reset is asserted, whatever the
    // registered state happens to be in that cycle.
    assign in_ready  = (state_q == S_IDLE) && has_room && !rst;
    assign mul_start = (state_q == S_ISSUE) && !rst;
    assign busy      = (state_q != S_IDLE) && !rst;
    assign out_valid = (count_q != '0) && !rst;

    assign accept = in_valid && in_ready;
    assign pop    = out_valid && out_ready;

    assign mul_op1 = op1_q;
    assign mul_op2 = op2_q;
    assign count   = count_q;

    assign head         = mem_q[rd_ptr_q];
    assign out_timeout  = head[33];
    assign out_overflow = head[32];
    assign out_result   = head[31:0];

    always_comb begin
        state_d   = state_q;
        op1_d     = op1_q;
        op2_d     = op2_q;
        wd_d      = wd_q;
        push      = 1'b0;
        push_data = '0;
        unique case (state_q)
            S_IDLE: begin
                // mul_done is deliberately ignored here; late completions
                // after a timeout or a reset must not create entries.
                if (accept) begin
                    op1_d   = in_op1;
                    op2_d   = in_op2;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wd_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                wd_d = wd_q + 1'b1;
                if (mul_done) begin
                    // A completion in the expiry cycle still counts as a real result.
                    push      = 1'b1;
                    push_data = {1'b0, mul_overflow, mul_result};
                    state_d   = S_IDLE;
                end else if (wd_q == WW'(TIMEOUT - 1)) begin
                    push      = 1'b1;
                    push_data = {1'b1, 1'b0, QNAN};
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Acceptance requires free space, so a push always has room.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op1_q    <= '0;
            op2_q    <= '0;
            wd_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            wd_q     <= wd_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: occupancy gates every read of it.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: doc/fp_mul_issue.md
# fp_mul_issue

Issue/collect stage directly upstream of the multi-cycle single-precision multiplier `multiple`. It accepts operand pairs over a valid/ready handshake and launches one multiply at a time with a single-cycle `mul_start`. It captures `mul_result`/`mul_overflow` on `mul_done` and buffers results in a small FIFO for the downstream consumer. A watchdog retires hung operations so the pipeline never deadlocks.

## Interface
- `DEPTH`, 4: result FIFO entries; power of two, ≥2.
- `TIMEOUT`, 64: WAIT cycles without `mul_done` before a forced retire; ≥2.

- `clk` input 1: single clock, all logic on rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `in_valid` input 1: upstream operand pair valid.
- `in_ready` output 1: block can accept a pair this cycle.
- `in_op1`, `in_op2` input 32 each: IEEE-754 single operands.
- `mul_start` output 1: one-cycle launch pulse to the multiplier.
- `mul_op1`, `mul_op2` output 32 each: registered operands to the multiplier.
- `mul_done` input 1: multiplier completion.
- `mul_overflow` input 1: multiplier overflow flag.
- `mul_result` input 32: multiplier product.
- `out_valid` output 1: FIFO head valid.
- `out_ready` input 1: downstream accepts the head.
- `out_result` output 32: head product.
- `out_overflow` output 1: head overflow flag.
- `out_timeout` output 1: head was retired by the watchdog.
- `busy` output 1: high in ISSUE or WAIT.
- `count` output $clog2(DEPTH)+1: FIFO occupancy.

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- IDLE: `in_ready = (count < DEPTH) && !rst`.
  - On `in_valid && in_ready`, latch `in_op1`/`in_op2` into `mul_op1`/`mul_op2` and go to ISSUE.
- ISSUE: `mul_start = 1` for exactly this cycle, then go to WAIT. Clear the watchdog counter.
- WAIT: `mul_op1`/`mul_op2` are held stable. The watchdog counter increments every cycle.
  - `mul_done == 1`: push {timeout=0, `mul_overflow`, `mul_result`} into the FIFO and go to IDLE.
  - Otherwise, when the counter reaches TIMEOUT-1: push {timeout=1, overflow=0, result=32'h7FC00000} and go to IDLE.
  - `mul_done` and timeout in the same cycle: `mul_done` wins, timeout=0.
- `mul_done` is ignored in IDLE and ISSUE. This covers a late done after reset or after a timeout.
- At most one operation is in flight. Acceptance requires `count < DEPTH`, so the eventual push can never overflow the FIFO.
- FIFO:
  - 34-bit entries {timeout, overflow, result}.
  - Read and write pointers wrap modulo DEPTH.
  - `out_valid = (count != 0)`; the head drives `out_result`/`out_overflow`/`out_timeout`.
  - A pop happens on `out_valid && out_ready`.
  - Simultaneous push and pop leaves `count` unchanged. The FIFO always has room at push time, so a push is never dropped.
  - Head outputs are don't-care when `out_valid = 0`; the bench checks them only when valid.
- Reset:
  - State IDLE; `count`, pointers and watchdog 0.
  - `mul_op1`/`mul_op2` = 0.
  - `mul_start`, `out_valid`, `busy`, `in_ready` = 0 during the reset cycle.
  - An in-flight op is abandoned, its result is never delivered, and FIFO contents are discarded.

## Timing
- Accept in cycle N → `mul_start` high in N+1 → WAIT from N+2.
- `mul_done` sampled high in WAIT cycle M → entry visible (`out_valid`, `count` incremented) in M+1. State is IDLE in M+1, so `in_ready` may be high in M+1.
- Minimum accept-to-`out_valid` latency is 3 cycles (done in N+2).
- Peak throughput is one op per (multiplier latency + 2) cycles.
- Timeout retire: entry visible TIMEOUT+2 cycles after acceptance with no done.
- `in_ready` is combinational from state and `count`. It is never asserted in ISSUE or WAIT.
- Pop in cycle K: the next entry appears at the head in K+1.

## Test plan
- **Reset:** hold `rst` 2 cycles with `mul_done=1` → all outputs 0; after release `in_ready=1`, `count=0`, no FIFO entry created.
- **Single op:** `in_op1=0x3FA00000`, `in_op2=0x3FC00000`; bench multiplier model returns done 3 cycles after start → `mul_start` one cycle at N+1, `out_result=0x3FF00000`, `out_overflow=0`, `out_timeout=0`.
- **Back-to-back with backpressure:**
  - Stimulus: `out_ready=0`; send 0x40000000×0x40400000, 0x3F800000×0xC0C00000, 0xC0400000×0xC0800000 and 0x40000000×0x40000000 (DEPTH=4).
  - Required: `in_ready` low while FIFO is full, and a 5th pair is not accepted.
  - Then `out_ready=1`: results pop in order 0x40C00000, 0xC0C00000, 0x41400000, 0x40800000.
- **Overflow passthrough:** model asserts `mul_overflow=1` with `mul_done` → head `out_overflow=1`, `count` increments by 1.
- **Watchdog:** model never asserts done (TIMEOUT=64) → entry appears 66 cycles after acceptance with `out_timeout=1`, `out_result=0x7FC00000`. A late done afterwards in IDLE creates no entry.
- **Simultaneous push/pop and mid-op reset:**
  - Push/pop: `count=1`, pop and push in the same cycle → `count` stays 1 and the new head is correct.
  - Mid-op reset: `rst` asserted in WAIT → IDLE, `count=0`; the subsequent `mul_done` is ignored.
